// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM among N_REQ pixel requesters.
// It issues one read per cycle, tags each response with the winner's ID and flags out-of-range reads.
module sprite_rom_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 6,
    parameter int MEM_DEPTH = 50176,
    parameter int ROM_LAT   = 1,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err
);

    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [ID_W-1:0]   win_s;
    logic              win_vld_s;
    logic              issue_s;
    logic              oor_s;
    logic [ADDR_W-1:0] sel_addr_s;

    logic [ROM_LAT-1:0] vld_q;
    logic [ROM_LAT-1:0] err_q;
    logic [ID_W-1:0]    id_q [ROM_LAT];

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end else begin
            sum = sum;
        end
        return ID_W'(sum);
    endfunction

    // Winner search starting at the round-robin pointer.
    always_comb begin
        win_vld_s = 1'b0;
        win_s     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_vld_s && req[wrap_idx(rr_ptr_q, k)]) begin
                win_vld_s = 1'b1;
                win_s     = wrap_idx(rr_ptr_q, k);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Grant, ROM address and next pointer; Reset suppresses any issue.
    always_comb begin
        issue_s    = win_vld_s && !Reset;
        sel_addr_s = req_addr[int'(win_s)*ADDR_W +: ADDR_W];
        oor_s      = 32'(sel_addr_s) >= 32'(MEM_DEPTH);
        gnt        = '0;
        rom_addr   = '0;
        rr_ptr_d   = rr_ptr_q;
        if (issue_s) begin
            gnt[win_s] = 1'b1;
            rom_addr   = oor_s ? '0 : sel_addr_s;
            rr_ptr_d   = (win_s == ID_W'(N_REQ - 1)) ? '0 : win_s + 1'b1;
        end else begin
            rr_ptr_d   = rr_ptr_q;
        end
    end

    // Pointer and response-tracking pipeline aligned with the ROM read latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr_q <= '0;
            vld_q    <= '0;
            err_q    <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q[0] <= issue_s;
            err_q[0] <= issue_s && oor_s;
            id_q[0]  <= issue_s ? win_s : '0;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    // ROM data arrives in the same cycle as the tracked tag, so data is gated here.
    always_comb begin
        rsp_valid = vld_q[ROM_LAT-1];
        rsp_id    = id_q[ROM_LAT-1];
        rsp_err   = vld_q[ROM_LAT-1] && err_q[ROM_LAT-1];
        if (vld_q[ROM_LAT-1] && !err_q[ROM_LAT-1]) begin
            rsp_data = rom_data;
        end else begin
            rsp_data = '0;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized and directed bench for sprite_rom_arbiter against a queue-based reference model
// and a behavioural ROM with a hashed content function.
module tb_sprite_rom_arbiter;
    localparam int N     = 4;
    localparam int AW    = 19;
    localparam int DW    = 6;
    localparam int DEPTH = 50176;
    localparam int LAT   = 2;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;

    sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .ROM_LAT(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .gnt(gnt), .rom_addr(rom_addr),
        .rom_data(rom_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] memf(input int a);
        int h;
        h = a ^ (a >> 6) ^ ((a >> 11) * 3) ^ 21;
        return DW'(h);
    endfunction

    // Behavioural ROM with LAT-cycle registered read.
    logic [DW-1:0] rom_pipe [LAT];
    always @(posedge Clk) begin
        rom_pipe[0] <= memf(int'(rom_addr));
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    typedef struct { int due; int id; bit err; int addr; } rsp_t;
    rsp_t q[$];
    int   rr;
    bit   pend [N];
    int   padr [N];
    bit   rearm;
    int   cyc;
    int   n_checks;
    int   n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int rand_addr();
        int sel;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0: return DEPTH;
            1: return DEPTH - 1;
            2: return (1 << AW) - 1;
            default: return int'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    task automatic step(input bit rst);
        int           w;
        int           idx;
        int           ea;
        logic [N-1:0] eg;
        rsp_t         e;
        @(negedge Clk);
        Reset = rst;
        for (int i = 0; i < N; i++) begin
            req[i] = pend[i];
            req_addr[i*AW +: AW] = AW'(padr[i]);
        end
        #1;
        w = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (w < 0 && pend[idx]) w = idx;
            end
        end
        eg = '0;
        ea = 0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            ea = (padr[w] < DEPTH) ? padr[w] : 0;
        end
        check_eq("gnt", 32'(gnt), 32'(eg));
        check_eq("rom_addr", 32'(rom_addr), 32'(ea));
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
            check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
            check_eq("rsp_data", 32'(rsp_data), e.err ? 32'd0 : 32'(memf(e.addr)));
        end else begin
            check_eq("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            check_eq("rsp_err_idle", 32'(rsp_err), 32'd0);
            check_eq("rsp_data_idle", 32'(rsp_data), 32'd0);
        end
        @(posedge Clk);
        if (rst) begin
            q.delete();
            rr = 0;
        end else if (w >= 0) begin
            q.push_back('{cyc + LAT, w, padr[w] >= DEPTH, padr[w]});
            rr = (w + 1) % N;
            pend[w] = rearm;
            if (rearm) padr[w] = rand_addr();
        end
        cyc++;
    endtask

    initial begin
        Reset = 1'b1;
        req = '0;
        req_addr = '0;
        rr = 0; cyc = 0; rearm = 1'b0; n_checks = 0; n_errors = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; padr[i] = 0; end

        repeat (3) step(1'b1);
        #2;
        check_eq("rsp_id_reset", 32'(rsp_id), 32'd0);

        // idle
        repeat (10) step(1'b0);
        // single request from requester 1
        pend[1] = 1'b1; padr[1] = 123;
        repeat (3) step(1'b0);
        // all four continuously from pointer 0
        step(1'b1);
        rearm = 1'b1;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b1; padr[i] = rand_addr(); end
        repeat (8) step(1'b0);
        rearm = 1'b0;
        repeat (6) step(1'b0);
        // range boundary
        pend[0] = 1'b1; padr[0] = DEPTH;
        repeat (3) step(1'b0);
        pend[0] = 1'b1; padr[0] = DEPTH - 1;
        repeat (3) step(1'b0);
        // wrap and skip from pointer 3
        pend[2] = 1'b1; padr[2] = 77;
        step(1'b0);
        rearm = 1'b1;
        pend[0] = 1'b1; padr[0] = 500;
        pend[2] = 1'b1; padr[2] = 600;
        repeat (3) step(1'b0);
        rearm = 1'b0;
        repeat (4) step(1'b0);
        // reset in the cycle after a grant
        pend[1] = 1'b1; padr[1] = 999;
        step(1'b0);
        pend[0] = 1'b1; padr[0] = 11;
        pend[3] = 1'b1; padr[3] = 33;
        step(1'b1);
        repeat (6) step(1'b0);

        // randomized traffic with occasional resets
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    padr[i] = rand_addr();
                end
            end
            step($urandom_range(0, 79) == 0);
        end
        for (int i = 0; i < N; i++) pend[i] = pend[i];
        repeat (N + LAT + 2) step(1'b0);
        check_eq("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
